// File: rtl/pipe_skid_reg.sv
// Flow-controlled pipeline stage register with a 2-entry skid buffer.
// Carries a control and a data bundle; in_ready is purely registered.
module pipe_skid_reg #(
    parameter int                 DATA_W    = 96,
    parameter int                 CTRL_W    = 8,
    parameter logic [CTRL_W-1:0]  CTRL_SAFE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Handshake: a beat moves on a port at the rising edge where both valid
    // and ready are high; valid never waits on ready, and in_ready depends
    // only on the skid register so no ready path crosses the stage.
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              acc;
    logic              pop;

    assign in_ready  = ~s_valid;
    assign acc       = in_valid & in_ready;
    assign pop       = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_SAFE;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_ctrl  <= CTRL_SAFE;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= CTRL_SAFE;
            s_data  <= '0;
        end else if (flush) begin
            // Bubble insertion: data is left untouched, only control is made safe.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ctrl  <= CTRL_SAFE;
            s_ctrl  <= CTRL_SAFE;
        end else begin
            case ({m_valid, s_valid})
                2'b00: begin
                    if (acc) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= in_ctrl;
                        m_data  <= in_data;
                    end
                end
                2'b10: begin
                    if (pop && acc) begin
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                    end else if (pop) begin
                        m_valid <= 1'b0;
                    end else if (acc) begin
                        s_valid <= 1'b1;
                        s_ctrl  <= in_ctrl;
                        s_data  <= in_data;
                    end
                end
                2'b11: begin
                    if (pop) begin
                        m_ctrl  <= s_ctrl;
                        m_data  <= s_data;
                        s_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The skid entry only ever fills behind a stalled main entry.
    skid_implies_main: assert property (@(posedge clk) disable iff (!rst)
        !(s_valid && !m_valid));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a long
// randomized run, all outputs compared against a queue of accepted beats.
module tb_pipe_skid_reg;

    localparam int            DATA_W = 96;
    localparam int            CTRL_W = 8;
    localparam logic [7:0]    SAFE   = 8'h3C;
    localparam int            W      = CTRL_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_SAFE(SAFE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .occupancy(occupancy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks    = 0;
    int errors    = 0;
    int pop_count = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of held beats: pushed when the input handshake completes, dropped
    // wholesale on flush or reset. Runs just after the monitor each cycle.
    always @(negedge clk) begin
        #1;
        if (!rst || flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end

    always @(negedge rst) exp_q.delete();

    // Monitor: compares the presented beat with the oldest accepted one.
    always @(negedge clk) begin
        if (rst) begin
            check("occupancy", occupancy, exp_q.size());
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_q.size() < 2);
            if (!out_valid) begin
                check("bubble_ctrl", out_ctrl, SAFE);
            end else if (exp_q.size() != 0) begin
                check("out_ctrl", out_ctrl, exp_q[0][W-1:DATA_W]);
                check("out_data", out_data, exp_q[0][DATA_W-1:0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pop_count++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [95:0] d,
                         input logic r, input logic f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // ---------------- stimulus ----------------
    logic [95:0] beats[4];
    int          idx;
    int          pc0;
    logic        saw_full;
    logic        saw_stall;
    logic        accepted;
    int unsigned seq;

    initial begin
        rst = 1'b0;
        drive(1'b1, 8'h81, 96'hA5, 1'b1, 1'b0);
        step();
        step();

        // 1: reset state, then first beat one edge after release
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ctrl", out_ctrl, SAFE);
        check("rst_out_data", out_data, 96'h0);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_out_ctrl", out_ctrl, 8'h81);
        check("t1_out_data", out_data, 96'hA5);
        check("t1_occupancy", occupancy, 2'd1);
        step();
        step();

        // 2: back-to-back stream with a 2-cycle downstream stall
        beats[0] = 96'h1; beats[1] = 96'h2; beats[2] = 96'h3; beats[3] = 96'h4;
        idx = 0; saw_full = 1'b0; saw_stall = 1'b0;
        pc0 = pop_count;
        for (int c = 0; c < 40; c++) begin
            if (idx < 4) drive(1'b1, 8'h10 + 8'(idx), beats[idx], !(c == 1 || c == 2), 1'b0);
            else         drive(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
            if (occupancy == 2'd2) saw_full = 1'b1;
            if (!in_ready) saw_stall = 1'b1;
            accepted = in_valid && in_ready;
            step();
            if (accepted) idx++;
            if (idx == 4 && occupancy == 2'd0) break;
        end
        check("t2_all_sent", idx, 4);
        check("t2_reached_full", saw_full, 1'b1);
        check("t2_in_ready_dropped", saw_stall, 1'b1);
        check("t2_pop_count", pop_count - pc0, 4);
        check("t2_drained", occupancy, 2'd0);

        // 3: flush while full and popping; skid beat must never appear
        drive(1'b1, 8'h31, 96'hAAA, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h32, 96'hBBB, 1'b0, 1'b0);
        step();
        check("t3_full", occupancy, 2'd2);
        pc0 = pop_count;
        drive(1'b0, 8'h00, 96'h0, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        check("t3_out_valid", out_valid, 1'b0);
        check("t3_out_ctrl", out_ctrl, SAFE);
        check("t3_occupancy", occupancy, 2'd0);
        check("t3_in_ready", in_ready, 1'b1);
        step();
        step();
        check("t3_pop_count", pop_count - pc0, 1);

        // 4: flush discards a beat offered into an empty stage
        drive(1'b1, 8'h44, 96'h444, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
        check("t4_out_valid", out_valid, 1'b0);
        check("t4_occupancy", occupancy, 2'd0);
        step();
        check("t4_out_valid_later", out_valid, 1'b0);

        // 5: asynchronous reset while full
        drive(1'b1, 8'h51, 96'h11, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h52, 96'h22, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("t5_full", occupancy, 2'd2);
        #2;
        rst = 1'b0;
        #1;
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_out_ctrl", out_ctrl, SAFE);
        check("t5_out_data", out_data, 96'h0);
        check("t5_occupancy", occupancy, 2'd0);
        step();
        step();
        rst = 1'b1;
        step();
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_empty", out_valid, 1'b0);

        // 6: randomized valid/ready/flush
        pc0 = pop_count;
        seq = 0;
        for (int c = 0; c < 10000; c++) begin
            seq++;
            drive($urandom_range(0, 3) != 0, 8'($urandom),
                  {$urandom, $urandom, seq}, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 49) == 0);
            step();
        end
        drive(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
        repeat (5) step();
        check("t6_drained", occupancy, 2'd0);
        check("t6_traffic", pop_count - pc0 > 1000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised, flow-controlled pipeline stage register; the next generation of the fixed MEM/WB-style stage registers.
- Carries a control bundle and a data bundle between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready fully registered, so stall back-pressure does not form a combinational path across stages.
- Supports synchronous flush (bubble insertion); control outputs are forced to a safe value whenever the stage holds a bubble.

Parameters:
- DATA_W, 96: width of the data bundle (e.g. MemData, ALUData, PC_8 concatenated).
- CTRL_W, 8: width of the control bundle (RegWrite, MemtoReg, jal, WB register, ...).
- CTRL_SAFE, 0: CTRL_W-bit value driven on out_ctrl when out_valid=0, and used as the reset value of the control registers.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush; discards all held and incoming beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat; registered.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  control bundle; equals CTRL_SAFE when out_valid=0.
- out_data  out  DATA_W  data bundle; holds its last value when out_valid=0.
- occupancy  out  2  number of held beats (0, 1 or 2).

Behaviour:
- Storage:
  - main entry (m_valid, m_ctrl, m_data) drives the outputs;
  - skid entry (s_valid, s_ctrl, s_data) holds one overflow beat.
- Reset (rst=0, async):
  - m_valid=s_valid=0; m_ctrl=s_ctrl=CTRL_SAFE; m_data=s_data=0.
  - Hence out_valid=0, out_ctrl=CTRL_SAFE, out_data=0, occupancy=0, in_ready=1.
- Derived signals:
  - in_ready = ~s_valid (register output only; no combinational dependence on out_ready).
  - acc = in_valid & in_ready.
  - pop = m_valid & out_ready.
  - out_valid = m_valid; out_ctrl = m_valid ? m_ctrl : CTRL_SAFE; occupancy = m_valid + s_valid.
- Latency: a beat accepted at edge N appears on the outputs after edge N (1 cycle) when the main entry is free or popping.
- Per-edge update, flush=0:
  - Empty (m=0, s=0): if acc, load main.
  - One (m=1, s=0):
    - pop & acc: main <= input.
    - pop & ~acc: m_valid <= 0.
    - ~pop & acc: skid <= input (occupancy becomes 2, in_ready drops next cycle).
    - ~pop & ~acc: hold.
  - Full (m=1, s=1), acc impossible:
    - pop: main <= skid, s_valid <= 0.
    - ~pop: hold.
  - State m=0, s=1 is unreachable and must never occur (assertion).
- Ordering: beats leave in strict acceptance order; no beat is duplicated or dropped except by flush.
- Flush=1 at an edge:
  - m_valid <= 0, s_valid <= 0, and both control registers <= CTRL_SAFE; data registers keep their values.
  - Flush has priority over acc and pop: a beat handshaken on in_* in that cycle is discarded, and the downstream pop in that cycle still completes.
  - in_ready=1 on the cycle after a flush.
- Reset asserted mid-operation: immediate return to reset values regardless of occupancy or handshake state; no beat survives.
- Widths: all bundles pass bit-exact; no arithmetic. occupancy never exceeds 2.

Test Plan:
1. Release reset with in_valid=1, in_ctrl=8'h81, in_data=96'hA5, out_ready=1 -> out_valid=1, out_ctrl=8'h81, out_data=96'hA5 after 1 edge; occupancy=1.
2. Stream 1,2,3,4 back-to-back; hold out_ready=0 for 2 cycles starting when beat 1 is on the outputs -> occupancy reaches 2, in_ready=0; beat 3 holds until space frees; output order is 1,2,3,4, each exactly once.
3. Occupancy=2, out_ready=1 and flush=1 on the same edge -> next cycle out_valid=0, out_ctrl=CTRL_SAFE, occupancy=0, in_ready=1; skid beat never appears.
4. Occupancy=0, in_valid=1 and flush=1 on the same edge -> beat discarded, out_valid stays 0.
5. Occupancy=2 with data 96'h11 and 96'h22; assert rst=0 asynchronously mid-cycle -> outputs go to reset values without waiting for a clock edge; after release, in_ready=1.
6. Random valid/ready/flush for 10k cycles against a queue model -> out_ctrl==CTRL_SAFE whenever out_valid=0; no loss, duplication or reordering outside flushes.
